// File: rtl/conv_rr_scheduler_if.sv
// Bundle between the round-robin conversion scheduler, its requester channels
// and the shared float-to-fixed converter.
interface conv_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int W     = 32
);
  logic [N_REQ-1:0]   REQ;
  logic [N_REQ*W-1:0] FLOAT_IN;
  logic [N_REQ-1:0]   GNT;
  logic [N_REQ-1:0]   DONE;
  logic [N_REQ-1:0]   ERR;
  logic [W-1:0]       RESULT_OUT;
  logic               BUSY;
  logic [W-1:0]       CONV_F;
  logic               CONV_BEGIN;
  logic               CONV_RST_FSM;
  logic               CONV_ACK;
  logic [W-1:0]       CONV_RESULT;

  modport master (
    input  REQ, FLOAT_IN, CONV_ACK, CONV_RESULT,
    output GNT, DONE, ERR, RESULT_OUT, BUSY, CONV_F, CONV_BEGIN, CONV_RST_FSM
  );

  modport slave (
    output REQ, FLOAT_IN, CONV_ACK, CONV_RESULT,
    input  GNT, DONE, ERR, RESULT_OUT, BUSY, CONV_F, CONV_BEGIN, CONV_RST_FSM
  );
endinterface

// File: rtl/conv_rr_scheduler.sv
// Round-robin scheduler sharing one float-to-fixed converter among N_REQ
// requesters, with begin/ack/re-arm sequencing and a WAIT watchdog.
module conv_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input logic                 CLK,
  input logic                 RST,
  conv_rr_scheduler_if.master bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESTART} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic             win_vld;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] gnt;
  logic             ok;
  logic [W-1:0]     result;
  logic [W-1:0]     conv_f;
  logic             ack_take;
  logic             timeout_hit;

  // Rotating-priority search: scan offsets high to low so the smallest offset
  // from the pointer is the last assignment and therefore wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (bus.REQ[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // ACK is only looked at in WAIT, so a stale level in IDLE/START is harmless;
  // ACK is tested before the watchdog so a coincident ACK still succeeds.
  always_comb begin
    state_nxt   = state;
    ack_take    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:    if (win_vld) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (bus.CONV_ACK) begin
          ack_take  = 1'b1;
          state_nxt = RESTART;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = RESTART;
        end
      end
      RESTART: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr    <= '0;
      gnt    <= '0;
      cnt    <= '0;
      ok     <= 1'b0;
      result <= '0;
      conv_f <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt    <= N_REQ'(1) << win;
            conv_f <= bus.FLOAT_IN[win*W +: W];
            ptr    <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
          end
        end
        START: cnt <= '0;
        WAIT: begin
          if (ack_take) begin
            ok     <= 1'b1;
            result <= bus.CONV_RESULT;
          end else if (timeout_hit) begin
            ok <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESTART: gnt <= '0;
        default: ;
      endcase
    end
  end

  // Pulses decode straight from registered state, so each is one clean cycle.
  assign bus.GNT          = gnt;
  assign bus.BUSY         = (state != IDLE);
  assign bus.CONV_BEGIN   = (state == START);
  assign bus.CONV_RST_FSM = (state == RESTART);
  assign bus.DONE         = (state == RESTART && ok)  ? gnt : '0;
  assign bus.ERR          = (state == RESTART && !ok) ? gnt : '0;
  assign bus.RESULT_OUT   = result;
  assign bus.CONV_F       = conv_f;

endmodule

// File: tb/tb_conv_rr_scheduler.sv
// Self-checking bench for conv_rr_scheduler: elapsed-cycle transaction model,
// stub converter, directed scenarios and a randomized phase.
module tb_conv_rr_scheduler;
  localparam int N_REQ   = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] RES_XOR = 32'h5A5A_A5A5;

  logic CLK = 1'b0;
  logic RST;

  conv_rr_scheduler_if #(.N_REQ(N_REQ), .W(W)) bus ();

  conv_rr_scheduler #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Transaction model: who holds the converter, when it started, when it ends.
  bit          m_busy;
  int          m_g, m_ptr, m_ts, m_end;
  bit          m_ok;
  logic [31:0] m_result, m_f;

  // Stub converter controls.
  bit          armed;
  int          st, d_cur;
  int          dmode;
  bit          stale;
  bit          fixed_res_en;
  logic [31:0] fixed_res;

  int want_order [5] = '{1, 2, 4, 8, 1};
  int order [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
  endtask

  function automatic int pick_delay();
    int r;
    if (dmode >= 0) return dmode;
    if (dmode == -1) return int'($urandom_range(1, 8));
    r = int'($urandom % 16);
    if (r == 0) return 0;
    if (r == 1) return TIMEOUT;
    if (r == 2) return TIMEOUT - 1;
    return int'($urandom_range(1, 8));
  endfunction

  task automatic compare();
    logic [31:0] eg;
    bit rb, rf;
    eg = m_busy ? (32'd1 << m_g) : 32'd0;
    rb = m_busy && (cyc == m_ts);
    rf = m_busy && (cyc == m_end);
    chk("gnt",          32'(bus.GNT),          eg);
    chk("busy",         32'(bus.BUSY),         32'(m_busy));
    chk("conv_begin",   32'(bus.CONV_BEGIN),   32'(rb));
    chk("conv_rst_fsm", 32'(bus.CONV_RST_FSM), 32'(rf));
    chk("done",         32'(bus.DONE),         (rf && m_ok)  ? eg : 32'd0);
    chk("err",          32'(bus.ERR),          (rf && !m_ok) ? eg : 32'd0);
    chk("result_out",   bus.RESULT_OUT,        m_result);
    chk("conv_f",       bus.CONV_F,            m_f);
  endtask

  task automatic stub();
    bit ack;
    if (RST)                   armed = 1'b0;
    else if (bus.CONV_RST_FSM) armed = 1'b0;
    else if (bus.CONV_BEGIN) begin
      armed = 1'b1;
      st    = cyc;
      d_cur = pick_delay();
    end
    ack = armed && (d_cur > 0) && (cyc >= st + d_cur);
    if (stale && (!bus.BUSY || bus.CONV_BEGIN)) ack = 1'b1;
    bus.CONV_ACK    = ack;
    bus.CONV_RESULT = fixed_res_en ? fixed_res : (bus.CONV_F ^ RES_XOR);
  endtask

  // One clock: capture inputs at the edge, advance the model, compare after
  // the edge, then drive the stub converter at the falling edge.
  task automatic step();
    logic             r_rst, r_ack;
    logic [N_REQ-1:0] r_req;
    logic [N_REQ*W-1:0] r_float;
    logic [31:0]      r_res;
    bit               found;
    int               e;
    @(posedge CLK);
    r_rst = RST; r_req = bus.REQ; r_float = bus.FLOAT_IN;
    r_ack = bus.CONV_ACK; r_res = bus.CONV_RESULT;
    cyc++;
    if (r_rst) begin
      m_busy = 0; m_g = 0; m_ptr = 0; m_ts = -100; m_end = -1;
      m_ok = 0; m_result = '0; m_f = '0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (m_ptr + k) % N_REQ;
        if (r_req[i] && !found) begin
          found = 1;
          m_g   = i;
        end
      end
      if (found) begin
        m_busy = 1; m_ts = cyc; m_end = -1;
        m_f    = r_float[m_g*W +: W];
        m_ptr  = (m_g + 1) % N_REQ;
      end
    end else if (cyc - 1 == m_end) begin
      m_busy = 0;
    end else begin
      e = cyc - 1 - m_ts;
      if (m_end < 0 && e >= 1) begin
        if (r_ack) begin
          m_ok = 1; m_result = r_res; m_end = cyc;
        end else if (e == TIMEOUT) begin
          m_ok = 0; m_end = cyc;
        end
      end
    end
    #1;
    compare();
    @(negedge CLK);
    stub();
  endtask

  task automatic wait_begin(input string name, output int s);
    bit got;
    got = 0;
    s   = -1;
    for (int t = 0; t < 20 && !got; t++) begin
      step();
      if (bus.CONV_BEGIN) begin
        got = 1;
        s   = cyc;
      end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 300; t++) begin
      step();
      if (bus.DONE != '0 || bus.ERR != '0) bus.REQ = bus.REQ & ~(bus.DONE | bus.ERR);
      if (!bus.BUSY && bus.REQ == '0) break;
    end
    chk(name, 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    int s, ng;
    bit got;
    logic [31:0] prev;
    RST = 1'b1; bus.REQ = '0; bus.FLOAT_IN = '0; bus.CONV_ACK = 1'b0; bus.CONV_RESULT = '0;
    m_busy = 0; m_g = 0; m_ptr = 0; m_ts = -100; m_end = -1; m_ok = 0; m_result = '0; m_f = '0;
    armed = 0; st = 0; d_cur = 0; dmode = -1; stale = 0; fixed_res_en = 0; fixed_res = '0;

    repeat (3) step();
    chk("reset_gnt",    32'(bus.GNT),  32'd0);
    chk("reset_busy",   32'(bus.BUSY), 32'd0);
    chk("reset_result", bus.RESULT_OUT, 32'd0);
    RST = 1'b0;
    step();

    // Single request, ACK on WAIT cycle 5.
    dmode = 5; fixed_res_en = 1; fixed_res = 32'h0001_8000;
    bus.REQ = 4'b0001; bus.FLOAT_IN[0 +: W] = 32'h3FC0_0000;
    step();
    chk("t1_gnt",    32'(bus.GNT),        32'd1);
    chk("t1_conv_f", bus.CONV_F,          32'h3FC0_0000);
    chk("t1_begin",  32'(bus.CONV_BEGIN), 32'd1);
    repeat (5) step();
    chk("t1_no_early_done", 32'(bus.DONE), 32'd0);
    step();
    chk("t1_done",    32'(bus.DONE),         32'd1);
    chk("t1_rst_fsm", 32'(bus.CONV_RST_FSM), 32'd1);
    chk("t1_result",  bus.RESULT_OUT,        32'h0001_8000);
    bus.REQ = '0; fixed_res_en = 0;
    drain("t1_idle");

    // All requesters held high: grants rotate 0,1,2,3,0.
    RST = 1'b1; step(); RST = 1'b0;
    dmode = -1; bus.REQ = '1;
    ng = 0;
    for (int t = 0; t < 200 && ng < 5; t++) begin
      for (int i = 0; i < N_REQ; i++) bus.FLOAT_IN[i*W +: W] = $urandom();
      step();
      if (bus.CONV_BEGIN) begin
        order[ng] = int'(bus.GNT);
        ng++;
        if (ng == 5) bus.REQ = bus.GNT;
      end
    end
    chk("t2_grant_count", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++) chk("t2_order", 32'(order[k]), 32'(want_order[k]));
    drain("t2_idle");

    // Converter never answers: ERR 65 cycles after START, result held.
    prev = m_result; dmode = 0; bus.REQ = 4'b0100;
    wait_begin("t3_begin", s);
    for (int k = 1; k <= 65; k++) begin
      step();
      if (k == 64) chk("t3_no_early_err", 32'(bus.ERR), 32'd0);
    end
    chk("t3_err",    32'(bus.ERR),  32'd4);
    chk("t3_nodone", 32'(bus.DONE), 32'd0);
    chk("t3_held",   bus.RESULT_OUT, prev);
    bus.REQ = 4'b0010; dmode = 2;
    wait_begin("t3_next_begin", s);
    repeat (3) step();
    chk("t3_next_done", 32'(bus.DONE), 32'd2);
    bus.REQ = '0;
    drain("t3_idle");

    // ACK lands on the watchdog's last cycle: success wins.
    dmode = TIMEOUT; bus.REQ = 4'b1000;
    wait_begin("t4_begin", s);
    repeat (65) step();
    chk("t4_done", 32'(bus.DONE), 32'd8);
    chk("t4_err",  32'(bus.ERR),  32'd0);
    bus.REQ = '0;
    drain("t4_idle");

    // Reset in WAIT, then pointer back at 0.
    dmode = 0; bus.REQ = 4'b0001;
    wait_begin("t5_begin", s);
    repeat (3) step();
    RST = 1'b1; bus.REQ = 4'b1010;
    step();
    chk("t5_gnt",    32'(bus.GNT),          32'd0);
    chk("t5_busy",   32'(bus.BUSY),         32'd0);
    chk("t5_result", bus.RESULT_OUT,        32'd0);
    chk("t5_conv_f", bus.CONV_F,            32'd0);
    chk("t5_rstfsm", 32'(bus.CONV_RST_FSM), 32'd0);
    RST = 1'b0; dmode = 3;
    step();
    chk("t5_first_gnt", 32'(bus.GNT), 32'd2);
    drain("t5_idle");

    // Stale ACK in IDLE and START.
    stale = 1; dmode = 4;
    repeat (3) step();
    chk("t6_idle_nodone", 32'(bus.DONE), 32'd0);
    bus.REQ = 4'b0100;
    wait_begin("t6_begin", s);
    got = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k < 5 && bus.DONE != '0) got = 1;
    end
    chk("t6_no_stale_done", 32'(got), 32'd0);
    chk("t6_done", 32'(bus.DONE), 32'd4);
    stale = 0; bus.REQ = '0;
    drain("t6_idle");

    // Randomized traffic with stale ACKs, timeouts and occasional reset.
    dmode = -2;
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < N_REQ; i++) bus.FLOAT_IN[i*W +: W] = $urandom();
      for (int i = 0; i < N_REQ; i++) begin
        if ((bus.DONE[i] || bus.ERR[i]) && ($urandom % 2 == 0)) bus.REQ[i] = 1'b0;
        else if (!bus.REQ[i] && ($urandom % 4 == 0)) bus.REQ[i] = 1'b1;
      end
      stale = ($urandom % 6 == 0);
      RST   = ($urandom % 150 == 0);
      step();
    end
    RST = 1'b0; stale = 0; bus.REQ = '0;
    drain("rand_idle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
